mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates a single-port synchronous block RAM between the fetch stage (instruction reads) and the memory stage (data loads/stores), so the five-stage pipeline can run from one unified memory. It sits between the IF/MEM stage memory interfaces and the RAM. It issues at most one access per cycle and tracks which requester owns the in-flight read. It routes read data back with a one-cycle latency.

## Interface
- `ADDR_W`, default 8: RAM word-address width; byte address bits `[ADDR_W+1:2]` are used.
- `STARVE_MAX`, default 4: consecutive data grants tolerated while fetch is waiting (fairness build only).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch read request; held with stable `if_addr` until `if_gnt`.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch request accepted this cycle (combinational).
- `if_rvalid` out 1: fetch read data valid.
- `if_rdata` out 32: fetch read data; 0 when `if_rvalid`=0.
- `dm_req` in 1: data request; held with stable `dm_addr`, `dm_wen`, `dm_wdata` until `dm_gnt`.
- `dm_wen` in 4: byte write enables; 0 = load, nonzero = store.
- `dm_addr` in 32: data byte address.
- `dm_wdata` in 32: store data.
- `dm_gnt` out 1: data request accepted this cycle (combinational).
- `dm_rvalid` out 1: load data valid.
- `dm_rdata` out 32: load data; 0 when `dm_rvalid`=0.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_wen` out 4: RAM byte write enables.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid one cycle after address.

## Operation
- Grant logic is combinational. At most one of `if_gnt`/`dm_gnt` is high per cycle.
- Only one requester pending: grant it.
- Both pending: grant data, unless fairness is enabled and `starve_cnt == STARVE_MAX`, in which case grant fetch.
- `STARVE_MAX`=0 in the fairness build gives fetch priority.
- RAM drive:
  - Granted requester's address goes to `ram_addr`.
  - `ram_wen` is `dm_wen` on a data grant, otherwise 0.
  - `ram_wdata` is `dm_wdata`.
  - With no grant: `ram_addr`=0, `ram_wen`=0, `ram_wdata`=0.
- Read-owner FSM, state register `owner`, updated every cycle:
  - IDLE → IDLE when there is no grant or a store grant.
  - → RD_IF on a fetch grant.
  - → RD_DM on a load grant (`dm_wen`=0).
  - The same transitions apply from RD_IF and RD_DM, so pipelined back-to-back reads are allowed.
- Response routing:
  - In RD_IF: `if_rvalid`=1, `if_rdata`=`ram_rdata`.
  - In RD_DM: `dm_rvalid`=1, `dm_rdata`=`ram_rdata`.
  - The other requester's rvalid/rdata are 0.
- Stores complete in the grant cycle and produce no rvalid.
- `starve_cnt` (width clog2(STARVE_MAX+1)):
  - +1, saturating at STARVE_MAX, when `dm_gnt` & `if_req`.
  - Cleared when `if_gnt` or `!if_req`.
- Reset: `owner`=IDLE, `starve_cnt`=0, both rvalid=0, both rdata=0. While `reset`=1, both gnt=0 and `ram_wen`=0. A read granted in the cycle before reset asserts yields no rvalid.

## Timing
- Grant latency 0: `gnt` is asserted in the same cycle as `req` when the arbiter selects it.
- Read latency 1: a grant at cycle T gives rvalid/rdata at T+1.
- Throughput: one access per cycle. Alternating owners on consecutive cycles route correctly.
- Store at T followed by a load of the same word granted at T+1: the load returns the new data at T+2.
- Requesters may change req/addr in the cycle after their grant. Changing them before the grant is illegal (unchecked).

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - `starve_cnt` is implemented.
  - Fetch is granted once data has won STARVE_MAX consecutive contested cycles.
- Not defined:
  - Strict data priority; fetch can starve while `dm_req` stays high.
  - No counter logic; STARVE_MAX is ignored.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=0x10 at T, RAM word 4 = 0x2402_0001 → `if_gnt`=1 at T. At T+1, `if_rvalid`=1 and `if_rdata`=0x2402_0001; `dm_rvalid`=0.
- Store then load: data store `dm_wen`=4'b0011, `dm_addr`=0x20, `dm_wdata`=0xAAAA_BBBB onto word 0x1234_5678, then a load of 0x20 → no rvalid after the store. Load returns 0x1234_BBBB one cycle after its grant.
- Contention, default build: both req held for 3 cycles → `dm_gnt` all 3 cycles, `if_gnt`=0. With `MEM_ARB_FAIRNESS_EN`, STARVE_MAX=2, both req held for 4 cycles → grants DM, DM, IF, DM.
- Back-to-back reads: fetch grant at T, load grant at T+1 → `if_rvalid` only at T+1, `dm_rvalid` only at T+2, each with its own word's data.
- Reset mid-read: fetch granted at T, `reset`=1 at T+1 → `if_rvalid`=0 at T+1, all gnt=0 and `ram_wen`=0 during reset, `starve_cnt`=0 afterward.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the fetch
// stage (instruction reads) and the memory stage (loads/stores).
// Grants are combinational and at most one access is issued per cycle.
// A registered read-owner state steers the RAM read data, which arrives one
// cycle after the address, back to whichever requester issued the read.
// Optional build macro: MEM_ARB_FAIRNESS_EN adds a starvation counter so that
// fetch wins a contested cycle after STARVE_MAX consecutive data wins.
// Without the macro, data always has priority and STARVE_MAX is ignored.

module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              dm_req,
   input  logic [3:0]        dm_wen,
   input  logic [31:0]       dm_addr,
   input  logic [31:0]       dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [31:0]       dm_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_wen,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [1:0] {
      OWN_IDLE  = 2'd0,
      OWN_RD_IF = 2'd1,
      OWN_RD_DM = 2'd2
   } owner_t;

   owner_t owner_r;
   logic   if_gnt_s;
   logic   dm_gnt_s;
   logic   fetch_wins_s;
   logic   if_rvalid_s;
   logic   dm_rvalid_s;
   logic   unused_addr_bits_s;

   // Only the word-address bits of the byte addresses reach the RAM.
   assign unused_addr_bits_s = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                 dm_addr[31:ADDR_W+2], dm_addr[1:0]};

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt_r;

   // Fetch overrides data priority once the starvation limit is reached.
   always_comb begin
      if (starve_cnt_r == STARVE_LIM) begin
         fetch_wins_s = 1'b1;
      end else begin
         fetch_wins_s = 1'b0;
      end
   end

   // Count consecutive data wins while fetch is waiting; clear when fetch is served or idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_r <= CNT_W'(0);
      end else if (if_gnt_s || !if_req) begin
         starve_cnt_r <= CNT_W'(0);
      end else if (dm_gnt_s && (starve_cnt_r != STARVE_LIM)) begin
         starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end
`else
   localparam int unused_starve_max = STARVE_MAX;

   // Strict data priority: fetch never overrides a pending data request.
   always_comb begin
      fetch_wins_s = 1'b0;
   end
`endif

   // Select at most one requester; nothing is granted while reset is held.
   always_comb begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
      if (reset) begin
         if_gnt_s = 1'b0;
         dm_gnt_s = 1'b0;
      end else begin
         case ({if_req, dm_req})
            2'b11: begin
               if (fetch_wins_s) begin
                  if_gnt_s = 1'b1;
               end else begin
                  dm_gnt_s = 1'b1;
               end
            end
            2'b10:   if_gnt_s = 1'b1;
            2'b01:   dm_gnt_s = 1'b1;
            default: begin
               if_gnt_s = 1'b0;
               dm_gnt_s = 1'b0;
            end
         endcase
      end
   end

   // Drive the RAM port from the granted requester, or park it at zero.
   always_comb begin
      ram_addr  = {ADDR_W{1'b0}};
      ram_wen   = 4'b0000;
      ram_wdata = 32'h0000_0000;
      if (if_gnt_s) begin
         ram_addr  = if_addr[ADDR_W+1:2];
         ram_wen   = 4'b0000;
         ram_wdata = dm_wdata;
      end else if (dm_gnt_s) begin
         ram_addr  = dm_addr[ADDR_W+1:2];
         ram_wen   = dm_wen;
         ram_wdata = dm_wdata;
      end else begin
         ram_addr  = {ADDR_W{1'b0}};
         ram_wen   = 4'b0000;
         ram_wdata = 32'h0000_0000;
      end
   end

   // Read-owner FSM: remembers who issued the read whose data returns next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_r <= OWN_IDLE;
      end else begin
         case (owner_r)
            OWN_IDLE, OWN_RD_IF, OWN_RD_DM: begin
               if (if_gnt_s) begin
                  owner_r <= OWN_RD_IF;
               end else if (dm_gnt_s && (dm_wen == 4'b0000)) begin
                  owner_r <= OWN_RD_DM;
               end else begin
                  owner_r <= OWN_IDLE;
               end
            end
            default: owner_r <= OWN_IDLE;
         endcase
      end
   end

   // Decode the owner; a read issued just before reset must not complete.
   always_comb begin
      if (reset) begin
         if_rvalid_s = 1'b0;
         dm_rvalid_s = 1'b0;
      end else begin
         if_rvalid_s = (owner_r == OWN_RD_IF);
         dm_rvalid_s = (owner_r == OWN_RD_DM);
      end
   end

   assign if_gnt    = if_gnt_s;
   assign dm_gnt    = dm_gnt_s;
   assign if_rvalid = if_rvalid_s;
   assign dm_rvalid = dm_rvalid_s;
   assign if_rdata  = if_rvalid_s ? ram_rdata : 32'h0000_0000;
   assign dm_rdata  = dm_rvalid_s ? ram_rdata : 32'h0000_0000;

endmodule
